// File: rtl/gyro_bias_cal.sv
// gyro_bias_cal: estimates the stationary per-axis gyro bias by averaging
// 2^CAL_LOG2 frames, then emits bias-corrected, saturated gyro frames.
//
// Handshake: gyr_new is a one-cycle strobe qualifying gyr (no backpressure);
// gyr_valid is a one-cycle strobe qualifying gyr_cal, raised exactly one
// cycle after the gyr_new it answers. cal_start is a one-cycle request that
// overrides everything else in the cycle it is sampled.
module gyro_bias_cal #(
    parameter int CAL_LOG2 = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [47:0]         gyr,
    input  logic                gyr_new,
    input  logic                cal_start,
    output logic [47:0]         gyr_cal,
    output logic                gyr_valid,
    output logic [47:0]         bias,
    output logic                cal_done,
    output logic [CAL_LOG2:0]   cal_count
);

    // Accumulator width: 2^CAL_LOG2 frames of 16-bit signed cannot overflow.
    localparam int AW = 16 + CAL_LOG2;
    localparam logic [CAL_LOG2:0] LAST_CNT = (CAL_LOG2 + 1)'((1 << CAL_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_CAL   = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Per-axis arrays: index 0 = Z [15:0], 1 = Y [31:16], 2 = X [47:32].
    logic signed [AW-1:0] acc [3];
    logic signed [AW-1:0] ext [3];
    logic        [16:0]   diff [3];
    logic        [47:0]   bias_nxt;
    logic        [47:0]   corr_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CAL;
        else     state <= state_nxt;
    end

    // Next-state logic; cal_start overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (cal_start) begin
            state_nxt = ST_CAL;
        end else begin
            case (state)
                ST_CAL:   if (gyr_new && cal_count == LAST_CNT) state_nxt = ST_LATCH;
                ST_LATCH: state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_RUN;
                default:  state_nxt = ST_CAL;
            endcase
        end
    end

    // Per-axis arithmetic: sign extension, averaged bias, saturated difference.
    always_comb begin
        bias_nxt = '0;
        corr_nxt = '0;
        for (int a = 0; a < 3; a++) begin
            ext[a]  = {{CAL_LOG2{gyr[16*a+15]}}, gyr[16*a +: 16]};
            // Arithmetic shift floors toward -inf; keep the low 16 bits.
            bias_nxt[16*a +: 16] = 16'(acc[a] >>> CAL_LOG2);
            diff[a] = {gyr[16*a+15], gyr[16*a +: 16]} - {bias[16*a+15], bias[16*a +: 16]};
            // Overflow of the 17-bit difference shows as bit 16 != bit 15.
            if (diff[a][16] != diff[a][15])
                corr_nxt[16*a +: 16] = diff[a][16] ? 16'h8000 : 16'h7fff;
            else
                corr_nxt[16*a +: 16] = diff[a][15:0];
        end
    end

    // Datapath registers: accumulation in CAL, bias latch, corrected output in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 3; a++) acc[a] <= '0;
            cal_count <= '0;
            bias      <= '0;
            gyr_cal   <= '0;
            gyr_valid <= 1'b0;
            cal_done  <= 1'b0;
        end else begin
            gyr_valid <= 1'b0;
            if (cal_start) begin
                // A coincident frame is discarded; bias and gyr_cal are held.
                for (int a = 0; a < 3; a++) acc[a] <= '0;
                cal_count <= '0;
                cal_done  <= 1'b0;
            end else begin
                case (state)
                    ST_CAL: begin
                        if (gyr_new) begin
                            for (int a = 0; a < 3; a++) acc[a] <= acc[a] + ext[a];
                            cal_count <= cal_count + 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        // Any frame arriving this cycle is dropped.
                        bias     <= bias_nxt;
                        cal_done <= 1'b1;
                        for (int a = 0; a < 3; a++) acc[a] <= '0;
                    end
                    ST_RUN: begin
                        if (gyr_new) begin
                            gyr_cal   <= corr_nxt;
                            gyr_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gyro_bias_cal.sv
// Testbench for gyro_bias_cal with CAL_LOG2 = 2 (4-frame calibration).
module tb_gyro_bias_cal;

    localparam int CAL_LOG2 = 2;
    localparam int NFR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [47:0]       gyr;
    logic              gyr_new;
    logic              cal_start;
    logic [47:0]       gyr_cal;
    logic              gyr_valid;
    logic [47:0]       bias;
    logic              cal_done;
    logic [CAL_LOG2:0] cal_count;

    int checks = 0;
    int errors = 0;

    // Reference model: calibration as sums of frames, bias as floor of the mean.
    int          m_sum [3];
    int          m_bias [3];
    int          m_cnt;
    bit          m_done;
    bit          m_latch;
    bit          m_valid;
    logic [47:0] m_cal;

    gyro_bias_cal #(.CAL_LOG2(CAL_LOG2)) dut (
        .clk(clk), .rst(rst), .gyr(gyr), .gyr_new(gyr_new), .cal_start(cal_start),
        .gyr_cal(gyr_cal), .gyr_valid(gyr_valid), .bias(bias),
        .cal_done(cal_done), .cal_count(cal_count)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [47:0] pack3(input int x, input int y, input int z);
        return {x[15:0], y[15:0], z[15:0]};
    endfunction

    function automatic logic [47:0] rand_frame();
        logic [47:0] f;
        for (int a = 0; a < 3; a++) begin
            case ($urandom_range(0, 3))
                0:       f[16*a +: 16] = 16'h8000;
                1:       f[16*a +: 16] = 16'h7fff;
                default: f[16*a +: 16] = 16'($urandom);
            endcase
        end
        return f;
    endfunction

    // Advance the model by one clock edge given the inputs sampled at it.
    task automatic model_edge(input bit r, input bit gn, input bit cs, input logic [47:0] g);
        int v [3];
        int d;
        int c [3];
        v[0] = int'($signed(g[47:32]));
        v[1] = int'($signed(g[31:16]));
        v[2] = int'($signed(g[15:0]));
        if (r) begin
            for (int a = 0; a < 3; a++) begin m_sum[a] = 0; m_bias[a] = 0; end
            m_cnt = 0; m_done = 0; m_latch = 0; m_valid = 0; m_cal = '0;
        end else begin
            m_valid = 0;
            if (cs) begin
                for (int a = 0; a < 3; a++) m_sum[a] = 0;
                m_cnt = 0; m_done = 0; m_latch = 0;
            end else if (m_latch) begin
                for (int a = 0; a < 3; a++) begin
                    m_bias[a] = $rtoi($floor(real'(m_sum[a]) / real'(NFR)));
                    m_sum[a] = 0;
                end
                m_done = 1; m_latch = 0;
            end else if (m_done) begin
                if (gn) begin
                    for (int a = 0; a < 3; a++) begin
                        d = v[a] - m_bias[a];
                        if (d > 32767) d = 32767;
                        if (d < -32768) d = -32768;
                        c[a] = d;
                    end
                    m_cal = pack3(c[0], c[1], c[2]);
                    m_valid = 1;
                end
            end else if (gn) begin
                for (int a = 0; a < 3; a++) m_sum[a] += v[a];
                m_cnt++;
                if (m_cnt == NFR) m_latch = 1;
            end
        end
    endtask

    // Driver: apply inputs for one edge, then sample #1 after it.
    task automatic drive(input bit gn, input bit cs, input logic [47:0] g, input bit r);
        gyr_new = gn; cal_start = cs; gyr = g; rst = r;
        @(posedge clk);
        #1;
        model_edge(r, gn, cs, g);
        gyr_new = 1'b0; cal_start = 1'b0; rst = 1'b0; gyr = rand_frame();
    endtask

    task automatic test_reset();
        drive(0, 0, rand_frame(), 1);
        drive(1, 0, rand_frame(), 1);
        checks++; if (gyr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", gyr_valid); end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", cal_done); end
        checks++; if (cal_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", cal_count); end
        checks++; if (bias !== 48'h0) begin errors++; $display("FAIL reset_bias got %h exp 0", bias); end
        checks++; if (gyr_cal !== 48'h0) begin errors++; $display("FAIL reset_gyr_cal got %h exp 0", gyr_cal); end
    endtask

    task automatic test_basic_cal();
        int fx [4] = '{100, 102, 98, 100};
        int fy [4] = '{-3, -4, -4, -4};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, pack3(fx[i], fy[i], -100), 0);
            checks++; if (gyr_valid !== 1'b0) begin errors++; $display("FAIL cal_valid frame %0d got %0b exp 0", i, gyr_valid); end
            checks++; if (cal_count !== 3'(i + 1)) begin errors++; $display("FAIL cal_count frame %0d got %0d exp %0d", i, cal_count, i + 1); end
            checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL cal_done_early frame %0d got %0b exp 0", i, cal_done); end
            if (i < 3) begin
                drive(0, 0, rand_frame(), 0);
                checks++; if (gyr_valid !== 1'b0) begin errors++; $display("FAIL cal_idle_valid got %0b exp 0", gyr_valid); end
            end
        end
        drive(0, 0, rand_frame(), 0);
        checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL cal_done got %0b exp 1", cal_done); end
        checks++; if (bias !== pack3(100, -4, -100)) begin errors++; $display("FAIL cal_bias got %h exp %h", bias, pack3(100, -4, -100)); end
    endtask

    task automatic test_correction();
        drive(1, 0, pack3(110, 0, -90), 0);
        checks++; if (gyr_valid !== 1'b1) begin errors++; $display("FAIL corr_valid got %0b exp 1", gyr_valid); end
        checks++; if (gyr_cal !== pack3(10, 4, 10)) begin errors++; $display("FAIL corr_value got %h exp %h", gyr_cal, pack3(10, 4, 10)); end
        drive(0, 0, rand_frame(), 0);
        checks++; if (gyr_valid !== 1'b0) begin errors++; $display("FAIL corr_pulse_len got %0b exp 0", gyr_valid); end
        checks++; if (gyr_cal !== pack3(10, 4, 10)) begin errors++; $display("FAIL corr_hold got %h exp %h", gyr_cal, pack3(10, 4, 10)); end
    endtask

    task automatic test_saturation();
        drive(1, 0, pack3(-32768, 5, 32700), 0);
        checks++; if (gyr_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0b exp 1", gyr_valid); end
        checks++; if (gyr_cal !== 48'h8000_0009_7fff) begin errors++; $display("FAIL sat_value got %h exp 800000097fff", gyr_cal); end
        drive(0, 0, rand_frame(), 0);
    endtask

    task automatic test_recal_collision();
        drive(1, 1, pack3(50, 50, 50), 0);
        checks++; if (gyr_valid !== 1'b0) begin errors++; $display("FAIL coll_valid got %0b exp 0", gyr_valid); end
        checks++; if (cal_count !== '0) begin errors++; $display("FAIL coll_count got %0d exp 0", cal_count); end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL coll_done got %0b exp 0", cal_done); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, pack3(0, 0, 0), 0);
            checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL recal_done frame %0d got %0b exp 0", i, cal_done); end
            checks++; if (bias !== pack3(100, -4, -100)) begin errors++; $display("FAIL recal_bias_hold got %h exp %h", bias, pack3(100, -4, -100)); end
            checks++; if (cal_count !== 3'(i + 1)) begin errors++; $display("FAIL recal_count got %0d exp %0d", cal_count, i + 1); end
        end
        drive(0, 0, rand_frame(), 0);
        checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL recal_done got %0b exp 1", cal_done); end
        checks++; if (bias !== 48'h0) begin errors++; $display("FAIL recal_bias got %h exp 0", bias); end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, rand_frame(), 0);
        for (int i = 0; i < 4; i++) drive(1, 0, pack3(8, -8, 8), 0);
        drive(1, 0, pack3(1000, 1000, 1000), 0);
        checks++; if (gyr_valid !== 1'b0) begin errors++; $display("FAIL b2b_latch_valid got %0b exp 0", gyr_valid); end
        checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL b2b_done got %0b exp 1", cal_done); end
        checks++; if (bias !== pack3(8, -8, 8)) begin errors++; $display("FAIL b2b_bias got %h exp %h", bias, pack3(8, -8, 8)); end
        drive(1, 0, pack3(20, 30, 40), 0);
        checks++; if (gyr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b exp 1", gyr_valid); end
        checks++; if (gyr_cal !== pack3(12, 38, 32)) begin errors++; $display("FAIL b2b_value got %h exp %h", gyr_cal, pack3(12, 38, 32)); end
        drive(1, 0, pack3(9, -7, 9), 0);
        checks++; if (gyr_cal !== pack3(1, 1, 1) || gyr_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%0b exp %h/1", gyr_cal, gyr_valid, pack3(1, 1, 1)); end
    endtask

    task automatic test_reset_mid_cal();
        drive(0, 1, rand_frame(), 0);
        drive(1, 0, pack3(7, 7, 7), 0);
        drive(1, 0, pack3(7, 7, 7), 0);
        drive(0, 0, rand_frame(), 1);
        checks++; if (cal_count !== '0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", cal_count); end
        checks++; if (bias !== 48'h0) begin errors++; $display("FAIL rstmid_bias got %h exp 0", bias); end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %0b exp 0", cal_done); end
        checks++; if (gyr_cal !== 48'h0) begin errors++; $display("FAIL rstmid_gyr_cal got %h exp 0", gyr_cal); end
        for (int i = 0; i < 3; i++) drive(1, 0, pack3(4, 4, 4), 0);
        drive(0, 0, rand_frame(), 0);
        drive(0, 0, rand_frame(), 0);
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL rstmid_3frames_done got %0b exp 0", cal_done); end
        drive(1, 0, pack3(4, 4, 4), 0);
        drive(0, 0, rand_frame(), 0);
        checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL rstmid_4frames_done got %0b exp 1", cal_done); end
        checks++; if (bias !== pack3(4, 4, 4)) begin errors++; $display("FAIL rstmid_bias_new got %h exp %h", bias, pack3(4, 4, 4)); end
    endtask

    task automatic test_random();
        bit r, cs, gn;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            cs = ($urandom_range(0, 39) == 0);
            gn = ($urandom_range(0, 9) < 6);
            drive(gn, cs, rand_frame(), r);
            checks++; if (gyr_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", n, gyr_valid, m_valid); end
            checks++; if (cal_done !== m_done) begin errors++; $display("FAIL rand_done cyc %0d got %0b exp %0b", n, cal_done, m_done); end
            checks++; if (cal_count !== 3'(m_cnt)) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", n, cal_count, m_cnt); end
            checks++; if (bias !== pack3(m_bias[0], m_bias[1], m_bias[2])) begin errors++; $display("FAIL rand_bias cyc %0d got %h exp %h", n, bias, pack3(m_bias[0], m_bias[1], m_bias[2])); end
            checks++; if (gyr_cal !== m_cal) begin errors++; $display("FAIL rand_gyr_cal cyc %0d got %h exp %h", n, gyr_cal, m_cal); end
        end
    endtask

    // Test sequence and final report.
    initial begin
        rst = 1'b1; gyr_new = 1'b0; cal_start = 1'b0; gyr = '0;
        test_reset();
        test_basic_cal();
        test_correction();
        test_saturation();
        test_recal_collision();
        test_back_to_back();
        test_reset_mid_cal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
